// File: rtl/ua_transmit_if.sv
// Byte-in / serial-out handshake bundle for the UART transmitter.
// The master drives bytes in, and the slave reports readiness, the line and Busy.
interface ua_transmit_if;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;
  logic       Busy;

  modport master (
    output DataIn,
    output DataInValid,
    input  DataInReady,
    input  SOut,
    input  Busy
  );

  modport slave (
    input  DataIn,
    input  DataInValid,
    output DataInReady,
    output SOut,
    output Busy
  );
endinterface

// File: rtl/ua_transmit.sv
// UART transmitter: a small byte FIFO feeds an 8N1 shift register.
// Back-to-back frames are sent with no idle gap between them.
module ua_transmit #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200,
  parameter int FifoDepth = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  ua_transmit_if.slave  tx
);

  localparam int BitTime = ClockFreq / BaudRate;
  localparam int CntW    = (BitTime > 1) ? $clog2(BitTime) : 1;
  localparam int PtrW    = $clog2(FifoDepth);
  localparam logic [CntW-1:0] TermCnt = CntW'(BitTime - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_State;
  state_t          w_NextState;
  logic [7:0]      r_Fifo [FifoDepth];
  logic [PtrW:0]   r_WrPtr;
  logic [PtrW:0]   r_RdPtr;
  logic [CntW-1:0] r_BitTmr;
  logic [3:0]      r_BitCnt;
  logic [9:0]      r_Shift;
  logic            r_SOut;

  logic w_Empty;
  logic w_Full;
  logic w_Ready;
  logic w_Push;
  logic w_Tick;
  logic w_LastBit;
  logic w_Load;
  logic w_ShiftEn;

  // Extra pointer MSB tells full from empty when the indices match.
  assign w_Empty = (r_WrPtr == r_RdPtr);
  assign w_Full  = (r_WrPtr[PtrW] != r_RdPtr[PtrW]) &&
                   (r_WrPtr[PtrW-1:0] == r_RdPtr[PtrW-1:0]);

  assign w_Ready   = !w_Full && !Reset;
  assign w_Push    = tx.DataInValid && w_Ready;
  assign w_Tick    = (r_BitTmr == TermCnt);
  assign w_LastBit = (r_BitCnt == 4'd1);

  assign tx.DataInReady = w_Ready;
  assign tx.SOut        = r_SOut;
  assign tx.Busy        = (r_State == SEND) || !w_Empty;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  always_comb begin
    w_NextState = r_State;
    unique case (r_State)
      IDLE: begin
        if (!w_Empty) begin
          w_NextState = SEND;
        end
      end
      SEND: begin
        if (w_Tick && w_LastBit && w_Empty) begin
          w_NextState = IDLE;
        end
      end
      default: w_NextState = IDLE;
    endcase
  end

  always_comb begin
    w_Load    = 1'b0;
    w_ShiftEn = 1'b0;
    unique case (r_State)
      IDLE: begin
        w_Load = !w_Empty;
      end
      SEND: begin
        if (w_Tick) begin
          if (w_LastBit) begin
            w_Load = !w_Empty;
          end else begin
            w_ShiftEn = 1'b1;
          end
        end
      end
      default: begin
        w_Load    = 1'b0;
        w_ShiftEn = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (w_Push) begin
      r_Fifo[r_WrPtr[PtrW-1:0]] <= tx.DataIn;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_WrPtr  <= '0;
      r_RdPtr  <= '0;
      r_BitTmr <= '0;
      r_BitCnt <= '0;
      r_Shift  <= '1;
      r_SOut   <= 1'b1;
    end else begin
      if (w_Push) begin
        r_WrPtr <= r_WrPtr + 1'b1;
      end
      if (w_Load) begin
        r_RdPtr <= r_RdPtr + 1'b1;
      end
      if (w_Load) begin
        r_Shift  <= {1'b1, r_Fifo[r_RdPtr[PtrW-1:0]], 1'b0};
        r_BitTmr <= '0;
        r_BitCnt <= 4'd10;
      end else if (r_State == SEND) begin
        r_BitTmr <= w_Tick ? '0 : r_BitTmr + 1'b1;
        if (w_ShiftEn) begin
          r_Shift  <= {1'b1, r_Shift[9:1]};
          r_BitCnt <= r_BitCnt - 4'd1;
        end
      end
      // Line follows the shifter one cycle behind, idle high.
      r_SOut <= (r_State == SEND) ? r_Shift[0] : 1'b1;
    end
  end

endmodule

// File: tb/tb_ua_transmit.sv
// Directed bench for ua_transmit at BitTime = 10 cycles.
// Checks the line bit by bit together with the FIFO handshake and Busy.
module tb_ua_transmit;

  logic Clock = 1'b0;
  logic Reset;

  ua_transmit_if tx ();

  ua_transmit #(
    .ClockFreq (1000),
    .BaudRate  (100),
    .FifoDepth (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .tx    (tx)
  );

  always #5 Clock = ~Clock;

  int   n_cmp = 0;
  int   n_err = 0;
  int   acc;
  logic chk_ready_low = 1'b0;
  logic pre_ready;
  logic last_ready;

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    tx.DataIn      = b;
    tx.DataInValid = 1'b1;
    step;
    tx.DataInValid = 1'b0;
  endtask

  // Frame cycle k starts at k = 0 on the first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input int first,
                             input int last);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = first; k < last; k++) begin
      chk($sformatf("sout_%0h[%0d]", b, k), 32'(tx.SOut), 32'(bits[k/10]));
      if (k < 99) begin
        chk($sformatf("busy_%0h[%0d]", b, k), 32'(tx.Busy), 32'd1);
      end
      if (chk_ready_low) begin
        chk("full_ready", 32'(tx.DataInReady), 32'd0);
      end
      if (k == 98) pre_ready = tx.DataInReady;
      if (k == 99) last_ready = tx.DataInReady;
      step;
    end
  endtask

  task automatic fill(input logic [7:0] first, output int n);
    tx.DataIn      = first;
    tx.DataInValid = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!tx.DataInReady) break;
      step;
      n++;
      tx.DataIn = tx.DataIn + 8'd1;
    end
  endtask

  initial begin
    Reset          = 1'b1;
    tx.DataIn      = 8'h77;
    tx.DataInValid = 1'b1;
    #1;
    chk("rst_ready", 32'(tx.DataInReady), 32'd0);
    step;
    step;
    chk("rst_ready2", 32'(tx.DataInReady), 32'd0);
    Reset          = 1'b0;
    tx.DataInValid = 1'b0;
    #1;
    chk("rst_sout", 32'(tx.SOut), 32'd1);
    chk("rst_busy", 32'(tx.Busy), 32'd0);
    chk("rst_ready_rel", 32'(tx.DataInReady), 32'd1);

    // Single byte 0x55 with exact first-bit latency.
    push1(8'h55);
    chk("s1_busy_push", 32'(tx.Busy), 32'd1);
    chk("s1_sout_push", 32'(tx.SOut), 32'd1);
    step;
    chk("s1_sout_pop", 32'(tx.SOut), 32'd1);
    step;
    check_frame(8'h55, 0, 100);
    chk("s1_busy_end", 32'(tx.Busy), 32'd0);
    chk("s1_sout_end", 32'(tx.SOut), 32'd1);

    // Byte 0xA5.
    push1(8'hA5);
    step;
    step;
    check_frame(8'hA5, 0, 100);
    chk("s2_busy_end", 32'(tx.Busy), 32'd0);

    // Streaming 0x01..0x06 with valid held high.
    fill(8'h01, acc);
    chk("s3_accepted", 32'(acc), 32'd5);
    chk("s3_ready_full", 32'(tx.DataInReady), 32'd0);
    check_frame(8'h01, 2, 100);
    chk("s3_ready_pre_pop", 32'(pre_ready), 32'd0);
    chk("s3_ready_post_pop", 32'(last_ready), 32'd1);
    chk("s3_ready_refull", 32'(tx.DataInReady), 32'd0);
    tx.DataInValid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      check_frame(8'(i), 0, 100);
    end
    chk("s3_busy_end", 32'(tx.Busy), 32'd0);
    chk("s3_sout_end", 32'(tx.SOut), 32'd1);

    // Reset 35 cycles into a 0xFF frame.
    push1(8'hFF);
    step;
    step;
    check_frame(8'hFF, 0, 35);
    Reset = 1'b1;
    #1;
    chk("s4_ready_in_rst", 32'(tx.DataInReady), 32'd0);
    step;
    Reset = 1'b0;
    #1;
    chk("s4_sout_after", 32'(tx.SOut), 32'd1);
    chk("s4_busy_after", 32'(tx.Busy), 32'd0);
    chk("s4_ready_after", 32'(tx.DataInReady), 32'd1);
    for (int i = 0; i < 30; i++) begin
      chk("s4_sout_quiet", 32'(tx.SOut), 32'd1);
      chk("s4_busy_quiet", 32'(tx.Busy), 32'd0);
      step;
    end

    // Push lands on the stop-bit terminal edge with one byte queued.
    push1(8'h3C);
    step;
    step;
    check_frame(8'h3C, 0, 10);
    tx.DataIn      = 8'h96;
    tx.DataInValid = 1'b1;
    check_frame(8'h3C, 10, 11);
    tx.DataInValid = 1'b0;
    check_frame(8'h3C, 11, 99);
    tx.DataIn      = 8'h69;
    tx.DataInValid = 1'b1;
    check_frame(8'h3C, 99, 100);
    tx.DataInValid = 1'b0;
    check_frame(8'h96, 0, 100);
    check_frame(8'h69, 0, 100);
    chk("s5_busy_end", 32'(tx.Busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("s5_no_dup", 32'(tx.SOut), 32'd1);
      step;
    end

    // Valid held for 20 cycles against a full FIFO.
    fill(8'h11, acc);
    chk("s6_accepted", 32'(acc), 32'd5);
    tx.DataIn     = 8'hEE;
    chk_ready_low = 1'b1;
    check_frame(8'h11, 2, 22);
    chk_ready_low  = 1'b0;
    tx.DataInValid = 1'b0;
    check_frame(8'h11, 22, 100);
    for (int i = 8'h12; i <= 8'h15; i++) begin
      check_frame(8'(i), 0, 100);
    end
    chk("s6_busy_end", 32'(tx.Busy), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("s6_no_extra", 32'(tx.SOut), 32'd1);
      step;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
